// File: rtl/round_referee_if.sv
// Signal bundle between the round referee and its environment.
// The generator and player side drive master; the referee is the slave.
interface round_referee_if;
    logic [1:0] player_choice;
    logic       player_lock;
    logic       new_match;
    logic [1:0] computer_choice;
    logic       stop_signal;
    logic [1:0] round_result;
    logic       result_valid;
    logic [3:0] player_score;
    logic [3:0] computer_score;
    logic       match_over;
    logic [1:0] match_winner;

    modport master (
        output player_choice, player_lock, new_match, computer_choice,
        input  stop_signal, round_result, result_valid, player_score,
               computer_score, match_over, match_winner
    );

    modport slave (
        input  player_choice, player_lock, new_match, computer_choice,
        output stop_signal, round_result, result_valid, player_score,
               computer_score, match_over, match_winner
    );
endinterface

// File: rtl/round_referee.sv
// Rock-Paper-Scissors round controller: freezes the choice generator on a lock,
// re-rolls Unset samples, judges the round and keeps match score.
module round_referee #(
    parameter int WIN_SCORE     = 3,
    parameter int SHOW_CYCLES   = 8,
    parameter int REROLL_CYCLES = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    round_referee_if.slave rr
);
    localparam int CMAX = (SHOW_CYCLES > REROLL_CYCLES) ? SHOW_CYCLES : REROLL_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SHOW_LAST   = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] REROLL_LAST = CW'(REROLL_CYCLES - 1);
    localparam logic [3:0]    WIN         = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_WAIT, S_LOCK, S_JUDGE, S_REROLL, S_SHOW, S_OVER
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_pchoice, w_pchoice;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_stop, w_stop;
    logic [1:0]      r_result, w_result;
    logic            r_valid, w_valid;
    logic [3:0]      r_pscore, w_pscore;
    logic [3:0]      r_cscore, w_cscore;
    logic            r_over, w_over;
    logic [1:0]      r_winner, w_winner;

    logic w_pwin, w_draw;
    assign w_draw = (r_pchoice == rr.computer_choice);
    assign w_pwin = (r_pchoice == 2'd2 && rr.computer_choice == 2'd1) ||
                    (r_pchoice == 2'd3 && rr.computer_choice == 2'd2) ||
                    (r_pchoice == 2'd1 && rr.computer_choice == 2'd3);

    always_comb begin
        w_state_nxt = r_state;
        w_pchoice   = r_pchoice;
        w_cnt       = r_cnt;
        w_stop      = r_stop;
        w_result    = r_result;
        w_valid     = 1'b0;
        w_pscore    = r_pscore;
        w_cscore    = r_cscore;
        w_over      = r_over;
        w_winner    = r_winner;

        if (rr.new_match) begin
            w_state_nxt = S_WAIT;
            w_pchoice   = 2'd0;
            w_cnt       = '0;
            w_stop      = 1'b0;
            w_result    = 2'd0;
            w_pscore    = 4'd0;
            w_cscore    = 4'd0;
            w_over      = 1'b0;
            w_winner    = 2'd0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    w_stop = 1'b0;
                    if (rr.player_lock && rr.player_choice != 2'd0) begin
                        w_pchoice   = rr.player_choice;
                        w_stop      = 1'b1;
                        w_state_nxt = S_LOCK;
                    end
                end
                S_LOCK: w_state_nxt = S_JUDGE;
                S_JUDGE: begin
                    w_cnt = '0;
                    if (rr.computer_choice == 2'd0) begin
                        w_stop      = 1'b0;
                        w_state_nxt = S_REROLL;
                    end else begin
                        w_valid     = 1'b1;
                        w_state_nxt = S_SHOW;
                        if (w_draw) begin
                            w_result = 2'd3;
                        end else if (w_pwin) begin
                            w_result = 2'd1;
                            if (r_pscore < WIN) w_pscore = r_pscore + 4'd1;
                            if (r_pscore + 4'd1 == WIN) begin
                                w_over   = 1'b1;
                                w_winner = 2'd1;
                            end
                        end else begin
                            w_result = 2'd2;
                            if (r_cscore < WIN) w_cscore = r_cscore + 4'd1;
                            if (r_cscore + 4'd1 == WIN) begin
                                w_over   = 1'b1;
                                w_winner = 2'd2;
                            end
                        end
                    end
                end
                S_REROLL: begin
                    // Generator free-runs here; re-freeze and give it a settle cycle.
                    if (r_cnt == REROLL_LAST) begin
                        w_stop      = 1'b1;
                        w_state_nxt = S_LOCK;
                    end else begin
                        w_cnt = r_cnt + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_stop      = 1'b0;
                        w_state_nxt = r_over ? S_OVER : S_WAIT;
                    end else begin
                        w_cnt = r_cnt + CW'(1);
                    end
                end
                S_OVER: w_stop = 1'b0;
                default: begin
                    w_state_nxt = S_WAIT;
                    w_stop      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_WAIT;
            r_pchoice <= 2'd0;
            r_cnt     <= '0;
            r_stop    <= 1'b0;
            r_result  <= 2'd0;
            r_valid   <= 1'b0;
            r_pscore  <= 4'd0;
            r_cscore  <= 4'd0;
            r_over    <= 1'b0;
            r_winner  <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pchoice <= w_pchoice;
            r_cnt     <= w_cnt;
            r_stop    <= w_stop;
            r_result  <= w_result;
            r_valid   <= w_valid;
            r_pscore  <= w_pscore;
            r_cscore  <= w_cscore;
            r_over    <= w_over;
            r_winner  <= w_winner;
        end
    end

    assign rr.stop_signal    = r_stop;
    assign rr.round_result   = r_result;
    assign rr.result_valid   = r_valid;
    assign rr.player_score   = r_pscore;
    assign rr.computer_score = r_cscore;
    assign rr.match_over     = r_over;
    assign rr.match_winner   = r_winner;
endmodule

// File: tb/tb_round_referee.sv
// Bench for round_referee: event-scheduled round model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_round_referee;
    localparam int W = 3, S = 8, R = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    round_referee_if rr();
    round_referee #(.WIN_SCORE(W), .SHOW_CYCLES(S), .REROLL_CYCLES(R)) dut (
        .clock(clock), .reset_n(reset_n), .rr(rr)
    );

    int n_tests = 0, n_fail = 0;

    // Model: a round is a timeline of edges since the accepting edge.
    int m_ps, m_cs, m_res, m_win, m_p;
    bit m_stop, m_valid, m_over, m_active;
    int t, jt, rt, et;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ps = 0; m_cs = 0; m_res = 0; m_win = 0; m_p = 0;
        m_stop = 0; m_valid = 0; m_over = 0; m_active = 0;
        t = 0; jt = -1; rt = -1; et = -1;
    endtask

    task automatic model_judge(input int c);
        if (c == 0) begin
            m_stop = 0;
            rt = t + R;
            jt = t + R + 2;
        end else begin
            m_valid = 1;
            et = t + S;
            if (m_p == c) m_res = 3;
            else if (c == ((m_p + 1) % 3) + 1) begin
                m_res = 1;
                if (m_ps < W) m_ps++;
                if (m_ps == W) begin m_over = 1; m_win = 1; end
            end else begin
                m_res = 2;
                if (m_cs < W) m_cs++;
                if (m_cs == W) begin m_over = 1; m_win = 2; end
            end
        end
    endtask

    task automatic model_step();
        if (!reset_n || rr.new_match) begin
            model_reset();
        end else begin
            m_valid = 0;
            if (!m_active) begin
                if (!m_over && rr.player_lock && rr.player_choice != 0) begin
                    m_active = 1; t = 0; jt = 2; rt = -1; et = -1;
                    m_p = int'(rr.player_choice);
                    m_stop = 1;
                end
            end else begin
                t++;
                if (t == jt) model_judge(int'(rr.computer_choice));
                if (t == rt) m_stop = 1;
                if (t == et) begin m_stop = 0; m_active = 0; end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (reset_n)
                chk("cycle{stop,res,vld,ps,cs,over,win}",
                    {rr.stop_signal, rr.round_result, rr.result_valid, rr.player_score,
                     rr.computer_score, rr.match_over, rr.match_winner},
                    {m_stop, 2'(m_res), m_valid, 4'(m_ps), 4'(m_cs), m_over, 2'(m_win)});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_lock(input int p);
        rr.player_choice = 2'(p);
        rr.player_lock = 1'b1;
        step(1);
        rr.player_lock = 1'b0;
    endtask

    task automatic pulse_new();
        rr.new_match = 1'b1;
        step(1);
        rr.new_match = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {rr.stop_signal, rr.round_result, rr.result_valid, rr.player_score,
                   rr.computer_score, rr.match_over, rr.match_winner}, 32'd0);
    endtask

    initial begin
        rr.player_choice = 0; rr.player_lock = 0; rr.new_match = 0; rr.computer_choice = 0;
        step(2);
        chk_all_zero("reset_outputs");
        reset_n = 1'b1;
        step(1);

        // basic player win
        rr.computer_choice = 1;
        pulse_lock(2);
        chk("win_stop_after_E0", rr.stop_signal, 1);
        chk("win_no_early_valid", rr.result_valid, 0);
        step(2);
        chk("win_valid", rr.result_valid, 1);
        chk("win_result", rr.round_result, 1);
        chk("win_pscore", rr.player_score, 1);
        step(7);
        chk("win_stop_last_show", rr.stop_signal, 1);
        step(1);
        chk("win_stop_fall", rr.stop_signal, 0);

        // draw then computer win
        rr.computer_choice = 3;
        pulse_lock(3);
        step(2);
        chk("draw_result", rr.round_result, 3);
        chk("draw_scores", {rr.player_score, rr.computer_score}, {4'd1, 4'd0});
        step(8);
        pulse_lock(2);
        step(2);
        chk("cwin_result", rr.round_result, 2);
        chk("cwin_cscore", rr.computer_score, 1);
        step(8);

        // re-roll
        rr.computer_choice = 0;
        pulse_lock(1);
        step(2);
        chk("reroll_stop_low", rr.stop_signal, 0);
        chk("reroll_no_valid", rr.result_valid, 0);
        rr.computer_choice = 3;
        step(3);
        chk("reroll_stop_still_low", rr.stop_signal, 0);
        step(1);
        chk("reroll_stop_back", rr.stop_signal, 1);
        step(2);
        chk("reroll_valid", rr.result_valid, 1);
        chk("reroll_result", rr.round_result, 1);
        chk("reroll_pscore", rr.player_score, 2);
        step(8);

        // match end, lock during SHOW ignored
        pulse_new();
        chk_all_zero("newmatch_clear1");
        rr.computer_choice = 1;
        for (int i = 0; i < 3; i++) begin
            pulse_lock(2);
            step(2);
            if (i == 0) begin
                pulse_lock(3);
                step(7);
            end else begin
                step(8);
            end
            if (i == 2) begin
                chk("match_over", rr.match_over, 1);
                chk("match_winner", rr.match_winner, 1);
            end
        end
        pulse_lock(2);
        step(3);
        chk("over_lock_ignored", {rr.player_score, rr.computer_score, 3'(rr.stop_signal)},
            {4'd3, 4'd0, 3'd0});
        pulse_new();
        chk_all_zero("newmatch_clear2");

        // unset lock ignored
        pulse_lock(0);
        step(2);
        chk("p0_ignored", {rr.stop_signal, rr.result_valid}, 2'b00);

        // new_match with lock on the same edge
        pulse_lock(2);
        step(10);
        chk("pre_simul_pscore", rr.player_score, 1);
        rr.new_match = 1'b1;
        pulse_lock(2);
        rr.new_match = 1'b0;
        step(3);
        chk_all_zero("simul_newmatch_wins");

        // async reset during SHOW
        pulse_lock(2);
        step(4);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        step(1);
        reset_n = 1'b1;
        step(1);
        rr.computer_choice = 3;
        pulse_lock(1);
        step(2);
        chk("post_reset_result", {rr.round_result, rr.player_score}, {2'd1, 4'd1});
        step(8);

        // random traffic
        repeat (3000) begin
            @(negedge clock);
            rr.player_lock     = ($urandom_range(0, 5) == 0);
            rr.player_choice   = 2'($urandom_range(0, 3));
            rr.computer_choice = ($urandom_range(0, 4) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            rr.new_match       = ($urandom_range(0, 199) == 0);
        end
        @(negedge clock);
        rr.player_lock = 0; rr.new_match = 0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/round_referee.md
# round_referee

Round controller that sits directly downstream of the computer-choice generator in the Rock-Paper-Scissors datapath. On a player lock-in it drives `stop_signal` to freeze the generator and samples the frozen `computer_choice`. It re-rolls when the generator yields Unset (0), then judges the round, keeps both scores and declares a match winner at `WIN_SCORE`.

## Interface

- `WIN_SCORE`, default 3: points needed to win a match; legal range 1..15.
- `SHOW_CYCLES`, default 8: cycles the result is held before the next round; legal range ≥1.
- `REROLL_CYCLES`, default 4: cycles `stop_signal` stays low when the computer choice is Unset; legal range ≥1.

Ports:

- `clock`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `player_choice`  in  2  1=Rock, 2=Paper, 3=Scissors, 0=Unset.
- `player_lock`  in  1  single-cycle pulse, player commits `player_choice`.
- `new_match`  in  1  single-cycle pulse, clears scores and restarts.
- `computer_choice`  in  2  frozen choice from the generator, same encoding.
- `stop_signal`  out  1  registered; high freezes the generator.
- `round_result`  out  2  0=none, 1=player wins, 2=computer wins, 3=draw.
- `result_valid`  out  1  one-cycle pulse when `round_result` updates.
- `player_score`  out  4  player points this match.
- `computer_score`  out  4  computer points this match.
- `match_over`  out  1  high once either score reaches `WIN_SCORE`.
- `match_winner`  out  2  0=none, 1=player, 2=computer.

## Operation

- **Reset.** State is WAIT_PLAYER. All outputs are 0. Latched player choice is 0.
- **States.** WAIT_PLAYER, LOCK, JUDGE, REROLL, SHOW, MATCH_OVER.
- **WAIT_PLAYER.** `stop_signal`=0.
  - `player_lock`=1 with `player_choice`≠0 latches the choice, sets `stop_signal`=1 and moves to LOCK.
  - A lock with `player_choice`=0 is ignored.
- **LOCK.** Lasts exactly 1 cycle, which gives the generator's latch edge time to settle. Then moves to JUDGE.
- **JUDGE.** Samples `computer_choice`.
  - If the sample is 0: `stop_signal`=0, move to REROLL.
  - Otherwise: compute the result, update scores, pulse `result_valid` and move to SHOW.
- **Judging rule.**
  - Player wins on (p,c) ∈ {(2,1),(3,2),(1,3)}.
  - Draw when p==c.
  - Computer wins otherwise.
  - The winner's score increments by 1; a draw changes no score.
- **REROLL.** `stop_signal` is held 0 for `REROLL_CYCLES` cycles, then set to 1 and the FSM returns to LOCK. There is no retry limit.
- **SHOW.** `stop_signal` stays 1 and `round_result` is held for `SHOW_CYCLES` cycles. On exit `stop_signal`=0 and the next state is:
  - MATCH_OVER if `match_over`=1;
  - WAIT_PLAYER otherwise.
- **Match end.** `match_over` and `match_winner` register on the same edge as the score that reaches `WIN_SCORE`. Scores saturate; no further increments occur.
- **MATCH_OVER.** `player_lock` is ignored. `stop_signal`=0. The FSM stays here until `new_match`.
- **new_match.** Highest priority in every state. On the next edge:
  - scores, `round_result`, `match_over`, `match_winner` and `stop_signal` clear to 0;
  - state goes to WAIT_PLAYER;
  - `result_valid` is not pulsed.
- **Simultaneous events.** `new_match` together with `player_lock`: `new_match` wins and the lock is dropped.
- **Locks while busy.** `player_lock` in any state other than WAIT_PLAYER is ignored and not queued.

## Timing

- Edge E0 samples `player_lock`. `stop_signal` is 1 after E0.
- Edge E1: LOCK→JUDGE.
- Edge E2: JUDGE samples `computer_choice`. Result, scores and the `result_valid` pulse are visible after E2 (latency 2 cycles from lock).
- Each re-roll adds `REROLL_CYCLES`+2 cycles.
- `stop_signal` falls after the last SHOW cycle. The earliest next accepted lock is at the edge following that fall.
- Asynchronous `reset_n` assertion mid-round forces reset values immediately, including `stop_signal`=0. Operation resumes on the first edge after deassertion.

## Test plan

- **Basic player win.** After reset, lock p=2 with `computer_choice`=1 → `result_valid` pulse 2 cycles after lock, `round_result`=1, `player_score`=1, `stop_signal` high for 1+1+8 cycles.
- **Draw and computer win.** p=3,c=3 → result 3, scores unchanged. Then p=2,c=3 → result 2, `computer_score`=1.
- **Re-roll.** `computer_choice`=0 at JUDGE → `stop_signal` low exactly 4 cycles, back high. Then c=3, p=1 → result 1. No `result_valid` during REROLL.
- **Match end.** Three player wins → `match_over`=1 and `match_winner`=1 at the third score edge. A further lock is ignored with scores held at 3/0. Then `new_match` → all zero, WAIT_PLAYER.
- **Ignored inputs and priority.** Lock with p=0 → no state change. Lock during SHOW → ignored. `new_match` and `player_lock` on the same edge → scores cleared, no round started.
- **Async reset.** `reset_n` low during SHOW → all outputs 0 immediately. A round after release proceeds normally.
